// File: rtl/operand_fetch_if.sv
// Operand fetch bus: instruction stream, register file read/write-back
// ports and the registered operand bundle toward the addressing-mode stage.
interface operand_fetch_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic [DATA_W-1:0] instr_data;
    logic              instr_valid;
    logic              instr_ready;

    logic [REG_AW-1:0] rf_raddr1;
    logic [DATA_W-1:0] rf_rdata1;
    logic [REG_AW-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata2;

    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [DATA_W-1:0] op1_data;
    logic [DATA_W-1:0] op2_data;
    logic [15:0]       op1_regaddr;
    logic [15:0]       op2_regaddr;
    logic [3:0]        op_opcode;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  instr_data, instr_valid,
        output instr_ready,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        input  wb_en, wb_addr, wb_data,
        output op1_data, op2_data,
        output op1_regaddr, op2_regaddr,
        output op_opcode, out_valid,
        input  out_ready
    );

    modport slave (
        output instr_data, instr_valid,
        input  instr_ready,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        output wb_en, wb_addr, wb_data,
        input  op1_data, op2_data,
        input  op1_regaddr, op2_regaddr,
        input  op_opcode, out_valid,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: decodes instruction words, reads the register file and
// emits a registered operand bundle. OPFETCH_BYPASS_EN adds write-back bypass.
module operand_fetch #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int ACC_ADDR = 0
) (
    input logic           clk,
    input logic           rst,
    operand_fetch_if.master bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EXT_WAIT = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;

    localparam logic [REG_AW-1:0] ACC = REG_AW'(ACC_ADDR);

    logic [1:0]        state;
    logic              pend_lda;
    logic [REG_AW-1:0] pend_rd;

    logic [3:0]        opc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic              is_ext;
    logic [REG_AW-1:0] raddr1;
    logic [REG_AW-1:0] raddr2;
    logic [DATA_W-1:0] samp1;
    logic [DATA_W-1:0] samp2;

    assign opc    = bus.instr_data[DATA_W-1 -: 4];
    assign rd     = bus.instr_data[DATA_W-5 -: REG_AW];
    assign rs     = bus.instr_data[DATA_W-5-REG_AW -: REG_AW];
    assign is_ext = (opc == 4'hC) || (opc == 4'hD);

    assign bus.instr_ready = (state != HOLD) || bus.out_ready;

    always_comb begin
        raddr1 = rd;
        raddr2 = rs;
        if (state == EXT_WAIT) begin
            raddr1 = pend_rd;
            raddr2 = ACC;
        end
    end

    assign bus.rf_raddr1 = raddr1;
    assign bus.rf_raddr2 = raddr2;

`ifdef OPFETCH_BYPASS_EN
    assign samp1 = (bus.wb_en && bus.wb_addr == raddr1) ?
                   bus.wb_data : bus.rf_rdata1;
    assign samp2 = (bus.wb_en && bus.wb_addr == raddr2) ?
                   bus.wb_data : bus.rf_rdata2;
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_en, bus.wb_addr, bus.wb_data};
    assign samp1     = bus.rf_rdata1;
    assign samp2     = bus.rf_rdata2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pend_lda        <= 1'b0;
            pend_rd         <= '0;
            bus.op1_data    <= '0;
            bus.op2_data    <= '0;
            bus.op1_regaddr <= '0;
            bus.op2_regaddr <= '0;
            bus.op_opcode   <= '0;
            bus.out_valid   <= 1'b0;
        end else begin
            unique case (state)
                EXT_WAIT: begin
                    if (bus.instr_valid) begin
                        state         <= HOLD;
                        bus.out_valid <= 1'b1;
                        if (pend_lda) begin
                            bus.op1_data    <= bus.instr_data;
                            bus.op1_regaddr <= '0;
                            bus.op2_data    <= samp2;
                            bus.op2_regaddr <= 16'(ACC);
                            bus.op_opcode   <= 4'hD;
                        end else begin
                            bus.op1_data    <= samp1;
                            bus.op1_regaddr <= 16'(pend_rd);
                            bus.op2_data    <= bus.instr_data;
                            bus.op2_regaddr <= '0;
                            bus.op_opcode   <= 4'hC;
                        end
                    end
                end
                default: begin
                    // HOLD with a stalled consumer keeps everything frozen
                    if (bus.instr_ready) begin
                        if (!bus.instr_valid) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                        end else if (is_ext) begin
                            state         <= EXT_WAIT;
                            pend_lda      <= (opc == 4'hD);
                            pend_rd       <= rd;
                            bus.out_valid <= 1'b0;
                        end else begin
                            state           <= HOLD;
                            bus.out_valid   <= 1'b1;
                            bus.op1_data    <= samp1;
                            bus.op2_data    <= samp2;
                            bus.op1_regaddr <= 16'(rd);
                            bus.op2_regaddr <= 16'(rs);
                            bus.op_opcode   <= opc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios followed by
// randomized word streams checked against a positional stream model.
module tb_operand_fetch;

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] ra1;
        logic [15:0] ra2;
        logic [3:0]  opc;
    } bundle_t;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] rf [8];
    assign bus.rf_rdata1 = rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf[bus.rf_raddr2];

    int checks = 0;
    int errors = 0;

    bundle_t     q [$];
    bit          pend = 0;
    bit          pend_lda = 0;
    logic [2:0]  pend_rd = '0;
    bit          rnd_mode = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rdv(input logic [2:0] a);
        if (BYP && bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return rf[a];
    endfunction

    // Positional interpretation of the accepted word stream
    task automatic model(input logic [15:0] w);
        bundle_t b;
        if (pend) begin
            pend = 0;
            if (pend_lda)
                b = '{w, rdv(3'd0), 16'd0, 16'd0, 4'hD};
            else
                b = '{rdv(pend_rd), w, {13'd0, pend_rd}, 16'd0, 4'hC};
            q.push_back(b);
        end else if (w[15:12] == 4'hC || w[15:12] == 4'hD) begin
            pend     = 1;
            pend_lda = (w[15:12] == 4'hD);
            pend_rd  = w[11:9];
        end else begin
            b = '{rdv(w[11:9]), rdv(w[8:6]), {13'd0, w[11:9]},
                  {13'd0, w[8:6]}, w[15:12]};
            q.push_back(b);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d,
                        input logic r);
        @(posedge clk);
        #2;
        bus.instr_valid = v;
        bus.instr_data  = d;
        bus.out_ready   = r;
        if (rnd_mode) begin
            rf[$urandom_range(7)] = 16'($urandom);
            bus.wb_en   = ($urandom_range(3) == 0);
            bus.wb_addr = 3'($urandom);
            bus.wb_data = 16'($urandom);
        end
        #1;
        if (v && bus.instr_ready) model(d);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst  = 1'b1;
        pend = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 50) begin
            step(1'b0, 16'h0, 1'b1);
            n++;
        end
        checks++;
        if (q.size() != 0 || bus.out_valid) begin
            errors++;
            $display("FAIL drain: %0d bundles left, out_valid %b",
                     q.size(), bus.out_valid);
        end
    endtask

    function automatic bundle_t cur();
        return '{bus.op1_data, bus.op2_data, bus.op1_regaddr,
                 bus.op2_regaddr, bus.op_opcode};
    endfunction

    bundle_t held;
    bit      stalled = 0;

    always @(negedge clk) begin
        bundle_t b;
        bundle_t e;
        if (rst) begin
            stalled = 0;
        end else begin
            b = cur();
            if (stalled) begin
                checks++;
                if (!bus.out_valid || b !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h v%b expected %h",
                             b, bus.out_valid, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bundle: got %h expected none", b);
                end else begin
                    e = q.pop_front();
                    if (b !== e) begin
                        errors++;
                        $display("FAIL bundle: got %h expected %h", b, e);
                    end
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = b;
        end
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_data  = '0;
        bus.out_ready   = 1'b0;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h0101);
        repeat (3) @(posedge clk);
        #3;
        chk("reset_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("reset_opcode", {12'd0, bus.op_opcode}, 16'd0);
        chk("reset_op1_data", bus.op1_data, 16'd0);
        chk("reset_op2_data", bus.op2_data, 16'd0);
        chk("reset_op1_regaddr", bus.op1_regaddr, 16'd0);
        chk("reset_op2_regaddr", bus.op2_regaddr, 16'd0);
        rst = 1'b0;
        #1;
        chk("reset_instr_ready", {15'd0, bus.instr_ready}, 16'd1);

        // MOV r1, r2
        rf[1] = 16'h1111;
        rf[2] = 16'h2222;
        step(1'b1, 16'hB280, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("mov_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("mov_op1", bus.op1_data, 16'h1111);
        chk("mov_op2", bus.op2_data, 16'h2222);
        chk("mov_ra1", bus.op1_regaddr, 16'd1);
        chk("mov_ra2", bus.op2_regaddr, 16'd2);
        chk("mov_opc", {12'd0, bus.op_opcode}, 16'hB);
        drain();

        // MVI r3 with a 3-cycle gap before the immediate
        rf[3] = 16'h3333;
        step(1'b1, 16'hC600, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b1);
            chk("mvi_gap_ready", {15'd0, bus.instr_ready}, 16'd1);
            chk("mvi_gap_valid", {15'd0, bus.out_valid}, 16'd0);
        end
        step(1'b1, 16'hBEEF, 1'b1);
        chk("mvi_pre_valid", {15'd0, bus.out_valid}, 16'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("mvi_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("mvi_op1", bus.op1_data, 16'h3333);
        chk("mvi_op2", bus.op2_data, 16'hBEEF);
        chk("mvi_ra1", bus.op1_regaddr, 16'd3);
        chk("mvi_ra2", bus.op2_regaddr, 16'd0);
        drain();

        // LDA with the accumulator at r0
        rf[0] = 16'h0005;
        step(1'b1, 16'hD000, 1'b1);
        step(1'b1, 16'h00AA, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("lda_op1", bus.op1_data, 16'h00AA);
        chk("lda_ra1", bus.op1_regaddr, 16'd0);
        chk("lda_op2", bus.op2_data, 16'h0005);
        chk("lda_ra2", bus.op2_regaddr, 16'd0);
        chk("lda_opc", {12'd0, bus.op_opcode}, 16'hD);
        drain();

        // Stall with a new MOV waiting, RF changing underneath
        step(1'b1, 16'h9280, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'hA4C0, 1'b0);
            if (i == 0) rf[1] = 16'h9999;
            chk("stall_ready", {15'd0, bus.instr_ready}, 16'd0);
            chk("stall_opc", {12'd0, bus.op_opcode}, 16'h9);
            chk("stall_op1", bus.op1_data, 16'h1111);
        end
        step(1'b1, 16'hA4C0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("nobubble_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("nobubble_opc", {12'd0, bus.op_opcode}, 16'hA);
        drain();

        // Reset during EXT_WAIT discards the MVI
        step(1'b1, 16'hC600, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        do_reset();
        step(1'b1, 16'hB280, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("post_rst_opc", {12'd0, bus.op_opcode}, 16'hB);
        chk("post_rst_op1", bus.op1_data, 16'h9999);
        drain();

        // Write-back collision on rs
        rf[2]       = 16'h2222;
        bus.wb_en   = 1'b1;
        bus.wb_addr = 3'd2;
        bus.wb_data = 16'h7777;
        step(1'b1, 16'hB280, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        bus.wb_en = 1'b0;
        chk("bypass_op2", bus.op2_data, BYP ? 16'h7777 : 16'h2222);
        drain();

        // Randomized stream
        rnd_mode = 1;
        begin
            logic [15:0] w;
            logic        v;
            logic        acc;
            w   = '0;
            acc = 1'b1;
            for (int i = 0; i < 600; i++) begin
                if (acc) begin
                    v = ($urandom_range(9) < 7);
                    w = 16'($urandom);
                    if ($urandom_range(3) == 0)
                        w[15:12] = ($urandom_range(1) == 1) ? 4'hC : 4'hD;
                end
                step(v, w, ($urandom_range(9) < 7));
                acc = !(v && !bus.instr_ready);
            end
        end
        rnd_mode  = 0;
        bus.wb_en = 1'b0;
        if (pend) begin
            step(1'b1, 16'h1234, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
